// File: rtl/reg_file_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_bank
// Description : Eight-entry Y86 architectural register file. Per-register
//               write enables and data come from the write-back decoder. Two
//               combinational read ports include same-cycle write bypass. A
//               handshaked dump port streams all registers in id order.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_bank #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // write-back inputs, one enable/data pair per register
  input  logic             en_0,
  input  logic             en_1,
  input  logic             en_2,
  input  logic             en_3,
  input  logic             en_4,
  input  logic             en_5,
  input  logic             en_6,
  input  logic             en_7,
  input  logic [WIDTH-1:0] D_0,
  input  logic [WIDTH-1:0] D_1,
  input  logic [WIDTH-1:0] D_2,
  input  logic [WIDTH-1:0] D_3,
  input  logic [WIDTH-1:0] D_4,
  input  logic [WIDTH-1:0] D_5,
  input  logic [WIDTH-1:0] D_6,
  input  logic [WIDTH-1:0] D_7,
  // decode read ports
  input  logic [2:0]       srcA,
  input  logic             reqA,
  output logic [WIDTH-1:0] valA,
  input  logic [2:0]       srcB,
  input  logic             reqB,
  output logic [WIDTH-1:0] valB,
  // debug dump port
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [2:0]       dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  localparam logic [2:0] c_LAST_IDX = 3'(NREGS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // gathered write-back inputs
  logic [NREGS-1:0] w_en;
  logic [WIDTH-1:0] w_d   [NREGS];
  // storage and its bypassed view (what a read would see this cycle)
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] w_fwd  [NREGS];

  // dump FSM state
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [2:0]       w_idx_nxt;

  assign w_en = {en_7, en_6, en_5, en_4, en_3, en_2, en_1, en_0};
  assign w_d[0] = D_0;
  assign w_d[1] = D_1;
  assign w_d[2] = D_2;
  assign w_d[3] = D_3;
  assign w_d[4] = D_4;
  assign w_d[5] = D_5;
  assign w_d[6] = D_6;
  assign w_d[7] = D_7;

  // Register storage: each enabled register commits its data independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_en[i]) regs_q[i] <= w_d[i];
      end
    end
  end

  // Bypassed register view: a write in flight wins over stored contents.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_fwd[i] = w_en[i] ? w_d[i] : regs_q[i];
    end
  end

  // Read ports return zero when not requested.
  assign valA = reqA ? w_fwd[srcA] : '0;
  assign valB = reqB ? w_fwd[srcB] : '0;

  assign w_idx_nxt = idx_q + 3'd1;

  // Dump FSM state register; reset aborts any dump without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Dump FSM next state: beats are snapshots taken when loaded, so later
  // writes to an already-loaded register do not disturb a stalled beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (dump_req) begin
          data_d  = w_fwd[0];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          if (idx_q == c_LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = w_idx_nxt;
            data_d = w_fwd[w_idx_nxt];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dump_valid = (state_q == S_SEND);
  assign dump_busy  = (state_q == S_SEND);
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;
  assign dump_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_bank
// Description : Scoreboard bench for reg_file_bank. Stimulus pushes expected
//               read results, dump beats and done pulses into queues; a
//               monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_bank;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } rd_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en;
  logic [31:0] D [8];
  logic [2:0]  srcA, srcB;
  logic        reqA, reqB;
  logic [31:0] valA, valB;
  logic        dump_req, dump_ready;
  logic        dump_valid, dump_busy, dump_done;
  logic [2:0]  dump_idx;
  logic [31:0] dump_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rd_chk = 1'b0;

  beat_t beat_q[$];
  int    done_q[$];
  rd_t   rd_q[$];

  reg_file_bank #(.WIDTH(32), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_0(en[0]), .en_1(en[1]), .en_2(en[2]), .en_3(en[3]),
    .en_4(en[4]), .en_5(en[5]), .en_6(en[6]), .en_7(en[7]),
    .D_0(D[0]), .D_1(D[1]), .D_2(D[2]), .D_3(D[3]),
    .D_4(D[4]), .D_5(D[5]), .D_6(D[6]), .D_7(D[7]),
    .srcA(srcA), .reqA(reqA), .valA(valA),
    .srcB(srcB), .reqB(reqB), .valB(valB),
    .dump_req(dump_req), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle index of the cycle that begins at each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic expect_rd(input logic [31:0] a, input logic [31:0] b);
    rd_t r;
    r.a = a;
    r.b = b;
    rd_q.push_back(r);
    rd_chk = 1'b1;
  endtask

  task automatic expect_beat(input int idx, input logic [31:0] data, input int c);
    beat_t e;
    e.idx  = idx;
    e.data = data;
    e.cyc  = c;
    beat_q.push_back(e);
  endtask

  // Monitor: compares every presented beat, done pulse and requested read.
  always @(negedge clk) begin
    chk("busy_eq_valid", 32'(dump_busy), 32'(dump_valid));
    if (dump_valid) begin
      if (beat_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual idx=%0d data=0x%08h required no beat (cycle %0d)",
                 dump_idx, dump_data, cyc);
      end else begin
        chk("beat_idx", 32'(dump_idx), 32'(beat_q[0].idx));
        chk("beat_data", dump_data, beat_q[0].data);
        if (dump_ready) begin
          chk("beat_cycle", 32'(cyc), 32'(beat_q[0].cyc));
          void'(beat_q.pop_front());
        end
      end
    end
    if (dump_done) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", 32'(cyc), 32'(done_q[0]));
        void'(done_q.pop_front());
      end
    end
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_queue_empty actual=empty required=entry (cycle %0d)", cyc);
      end else begin
        chk("valA", valA, rd_q[0].a);
        chk("valB", valB, rd_q[0].b);
        void'(rd_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    en = '0;
    for (int i = 0; i < 8; i++) D[i] = '0;
    srcA = 3'd3; reqA = 1'b1;
    srcB = 3'd7; reqB = 1'b1;
    dump_req = 1'b0; dump_ready = 1'b1;

    // reset state of dump port and reads
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    chk("rst_idx", 32'(dump_idx), 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_valA", valA, 32'd0);
    tick();
    rst_n = 1'b1;

    // reset then read
    tick(); expect_rd(32'd0, 32'd0);
    tick(); reqA = 1'b0; expect_rd(32'd0, 32'd0);

    // write then read: bypass in cycle N, storage in N+1, disabled write ignored
    tick(); en[2] = 1'b1; D[2] = 32'h1234_5678;
    srcA = 3'd2; reqA = 1'b1; srcB = 3'd2; reqB = 1'b1;
    expect_rd(32'h1234_5678, 32'h1234_5678);
    tick(); en[2] = 1'b0; D[2] = 32'hFFFF_FFFF;
    expect_rd(32'h1234_5678, 32'h1234_5678);
    tick(); reqA = 1'b0; D[2] = '0;
    expect_rd(32'h0, 32'h1234_5678);

    // simultaneous writes
    tick(); en[0] = 1'b1; D[0] = 32'hA; en[4] = 1'b1; D[4] = 32'hB;
    srcA = 3'd0; reqA = 1'b1; srcB = 3'd4;
    expect_rd(32'hA, 32'hB);
    tick(); en = '0; D[0] = '0; D[4] = '0;
    expect_rd(32'hA, 32'hB);

    // load regs[i] = i*0x11 in one cycle
    tick(); en = 8'hFF;
    for (int i = 0; i < 8; i++) D[i] = 32'(i * 32'h11);
    srcA = 3'd5; srcB = 3'd7;
    expect_rd(32'h55, 32'h77);
    tick(); en = '0;
    for (int i = 0; i < 8; i++) D[i] = '0;
    expect_rd(32'h55, 32'h77);

    // full dump without backpressure; a second request mid-dump is ignored
    tick(); n = cyc; dump_req = 1'b1; dump_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_beat(i, 32'(i * 32'h11), n + 1 + i);
    done_q.push_back(n + 9);
    tick(); dump_req = 1'b0;
    tick();
    tick(); dump_req = 1'b1;
    tick(); dump_req = 1'b0;
    repeat (8) tick();

    // backpressure on beat 2 while register 2 is overwritten
    tick(); n = cyc; dump_req = 1'b1;
    expect_beat(0, 32'h00, n + 1);
    expect_beat(1, 32'h11, n + 2);
    expect_beat(2, 32'h22, n + 6);
    for (int i = 3; i < 8; i++) expect_beat(i, 32'(i * 32'h11), n + 4 + i);
    done_q.push_back(n + 12);
    tick(); dump_req = 1'b0;
    tick();
    tick(); dump_ready = 1'b0; en[2] = 1'b1; D[2] = 32'hDEAD;
    tick(); en[2] = 1'b0; D[2] = '0;
    tick();
    tick(); dump_ready = 1'b1;
    repeat (8) tick();

    // later dump shows the new value
    tick(); n = cyc; dump_req = 1'b1;
    for (int i = 0; i < 8; i++)
      expect_beat(i, (i == 2) ? 32'hDEAD : 32'(i * 32'h11), n + 1 + i);
    done_q.push_back(n + 9);
    tick(); dump_req = 1'b0;
    repeat (10) tick();

    // reset asserted during beat 5
    tick(); n = cyc; dump_req = 1'b1;
    for (int i = 0; i < 5; i++)
      expect_beat(i, (i == 2) ? 32'hDEAD : 32'(i * 32'h11), n + 1 + i);
    tick(); dump_req = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_busy", 32'(dump_busy), 32'd0);
    chk("abort_idx", 32'(dump_idx), 32'd0);
    tick(); rst_n = 1'b1;
    reqA = 1'b1; reqB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); srcA = 3'(2 * i); srcB = 3'(2 * i + 1);
      expect_rd(32'd0, 32'd0);
    end
    repeat (4) tick();

    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("dones_left", 32'(done_q.size()), 32'd0);
    chk("reads_left", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
